// File: rtl/sprite_animator_if.sv
// Scan-position, sprite-configuration and ROM-address bundle for sprite_animator.
// master = scan/config side, slave = the animator itself.
interface sprite_animator_if #(
  parameter int NUM_SPR    = 2,
  parameter int MAX_FRAMES = 4,
  parameter int ADDR_W     = 12,
  parameter int DIV_W      = 8
);
  localparam int FW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  logic [8:0]              row;
  logic [9:0]              col;
  logic [NUM_SPR-1:0]      spr_en;
  logic [NUM_SPR*10-1:0]   spr_x;
  logic [NUM_SPR*9-1:0]    spr_y;
  logic [NUM_SPR*ADDR_W-1:0] spr_base;
  logic [NUM_SPR*(FW+1)-1:0] spr_nframes;
  logic [NUM_SPR*DIV_W-1:0]  spr_div;
  logic [ADDR_W-1:0]       rom_addr;
  logic                    hit;
  logic [2:0]              hit_id;
  logic [NUM_SPR*FW-1:0]   frame_idx;

  modport master (
    output row, col, spr_en, spr_x, spr_y, spr_base, spr_nframes, spr_div,
    input  rom_addr, hit, hit_id, frame_idx
  );

  modport slave (
    input  row, col, spr_en, spr_x, spr_y, spr_base, spr_nframes, spr_div,
    output rom_addr, hit, hit_id, frame_idx
  );
endinterface

// File: rtl/sprite_animator.sv
// Multi-channel sprite ROM address generator: window hit, lowest-index priority, per-channel animation.
// Define SPRITE_ANIM_PINGPONG_EN to make frames bounce between the ends instead of wrapping.
module sprite_animator #(
  parameter int NUM_SPR    = 2,
  parameter int SPR_W      = 20,
  parameter int SPR_H      = 20,
  parameter int MAX_FRAMES = 4,
  parameter int ADDR_W     = 12,
  parameter int DIV_W      = 8
) (
  input  logic           clk,
  input  logic           reset,
  sprite_animator_if.slave bus
);
  localparam int FW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int NW = FW + 1;
  localparam logic [NW-1:0]     ONE_N    = NW'(1);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0] SPR_W_A  = ADDR_W'(SPR_W);
  localparam logic [10:0]       SPR_W11  = 11'(SPR_W);
  localparam logic [10:0]       SPR_H11  = 11'(SPR_H);

  logic              origin_q, origin_d;
  logic              vstart;
  logic [FW-1:0]     frame_q [NUM_SPR];
  logic [FW-1:0]     frame_d [NUM_SPR];
  logic [DIV_W-1:0]  tick_q  [NUM_SPR];
  logic [DIV_W-1:0]  tick_d  [NUM_SPR];
`ifdef SPRITE_ANIM_PINGPONG_EN
  logic [NUM_SPR-1:0] dir_q, dir_d;
`endif
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit_q, hit_d;
  logic [2:0]        hit_id_q, hit_id_d;

  // Animation steps once per video frame: rising edge of "scan is at the origin".
  always_comb begin
    origin_d = (bus.row == 9'd0) && (bus.col == 10'd0);
    vstart   = origin_d && !origin_q;
  end

  always_comb begin
    logic [NW-1:0]    nf;
    logic [NW-1:0]    cur;
    logic [DIV_W-1:0] div;
    logic             step;
    tick_d  = tick_q;
    frame_d = frame_q;
`ifdef SPRITE_ANIM_PINGPONG_EN
    dir_d   = dir_q;
`endif
    nf   = '0;
    cur  = '0;
    div  = '0;
    step = 1'b0;
    for (int i = 0; i < NUM_SPR; i++) begin
      nf   = bus.spr_nframes[NW*i +: NW];
      div  = bus.spr_div[DIV_W*i +: DIV_W];
      cur  = {1'b0, frame_q[i]};
      step = 1'b0;
      if (!bus.spr_en[i]) begin
        tick_d[i]  = '0;
        frame_d[i] = '0;
`ifdef SPRITE_ANIM_PINGPONG_EN
        dir_d[i]   = 1'b0;
`endif
      end else if (vstart) begin
        if (tick_q[i] == div) begin
          tick_d[i] = '0;
          step      = 1'b1;
        end else begin
          tick_d[i] = tick_q[i] + DIV_W'(1);
        end
      end
      if (step) begin
`ifdef SPRITE_ANIM_PINGPONG_EN
        // A frame left out of range by a shrunken nframes restarts forward from 0.
        if (nf <= ONE_N || cur >= nf) begin
          frame_d[i] = '0;
          dir_d[i]   = 1'b0;
        end else if (!dir_q[i]) begin
          if (cur + ONE_N == nf) begin
            dir_d[i]   = 1'b1;
            frame_d[i] = frame_q[i] - FW'(1);
          end else begin
            frame_d[i] = frame_q[i] + FW'(1);
          end
        end else begin
          if (frame_q[i] == '0) begin
            dir_d[i]   = 1'b0;
            frame_d[i] = FW'(1);
          end else begin
            frame_d[i] = frame_q[i] - FW'(1);
          end
        end
`else
        if (cur + ONE_N >= nf) begin
          frame_d[i] = '0;
        end else begin
          frame_d[i] = FW'(cur + ONE_N);
        end
`endif
      end
    end
  end

  // Descending scan so the lowest covering channel is the last writer.
  always_comb begin
    logic [10:0] row11;
    logic [10:0] col11;
    logic [10:0] x11;
    logic [10:0] y11;
    hit_d      = 1'b0;
    hit_id_d   = 3'd0;
    rom_addr_d = rom_addr_q;
    row11      = {2'b00, bus.row};
    col11      = {1'b0, bus.col};
    x11        = '0;
    y11        = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      x11 = {1'b0, bus.spr_x[10*i +: 10]};
      y11 = {2'b00, bus.spr_y[9*i +: 9]};
      if (bus.spr_en[i] &&
          row11 >= y11 && row11 < y11 + SPR_H11 &&
          col11 >= x11 && col11 < x11 + SPR_W11) begin
        hit_d      = 1'b1;
        hit_id_d   = 3'(i);
        rom_addr_d = bus.spr_base[ADDR_W*i +: ADDR_W]
                   + ADDR_W'(frame_q[i]) * FRAME_SZ
                   + ADDR_W'(row11 - y11) * SPR_W_A
                   + ADDR_W'(col11 - x11);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      origin_q   <= 1'b0;
      rom_addr_q <= '0;
      hit_q      <= 1'b0;
      hit_id_q   <= 3'd0;
      for (int i = 0; i < NUM_SPR; i++) begin
        tick_q[i]  <= '0;
        frame_q[i] <= '0;
      end
`ifdef SPRITE_ANIM_PINGPONG_EN
      dir_q      <= '0;
`endif
    end else begin
      origin_q   <= origin_d;
      rom_addr_q <= rom_addr_d;
      hit_q      <= hit_d;
      hit_id_q   <= hit_id_d;
      for (int i = 0; i < NUM_SPR; i++) begin
        tick_q[i]  <= tick_d[i];
        frame_q[i] <= frame_d[i];
      end
`ifdef SPRITE_ANIM_PINGPONG_EN
      dir_q      <= dir_d;
`endif
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.hit      = hit_q;
  assign bus.hit_id   = hit_id_q;

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_fidx
    assign bus.frame_idx[FW*g +: FW] = frame_q[g];
  end
endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed scenarios plus randomized epochs against a behavioural model.
`timescale 1ns/1ps
module tb_sprite_animator;
  localparam int NS = 2, SW = 20, SH = 20, MF = 4, AW = 12, DW = 8, FW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_animator_if #(.NUM_SPR(NS), .MAX_FRAMES(MF), .ADDR_W(AW), .DIV_W(DW)) bus();

  sprite_animator #(
    .NUM_SPR(NS), .SPR_W(SW), .SPR_H(SH), .MAX_FRAMES(MF), .ADDR_W(AW), .DIV_W(DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk, n_fail;
  int c_en[NS], c_x[NS], c_y[NS], c_base[NS], c_nf[NS], c_div[NS];
  int m_frame[NS], m_tick[NS], m_pos[NS];
  bit m_prev;
  int e_hit, e_id, e_addr;
  int cur_row, cur_col;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NS; i++) begin
      bus.spr_en[i]              = c_en[i] != 0;
      bus.spr_x[10*i +: 10]      = 10'(c_x[i]);
      bus.spr_y[9*i +: 9]        = 9'(c_y[i]);
      bus.spr_base[AW*i +: AW]   = AW'(c_base[i]);
      bus.spr_nframes[3*i +: 3]  = 3'(c_nf[i]);
      bus.spr_div[DW*i +: DW]    = DW'(c_div[i]);
    end
  endtask

  task automatic set_pix(input int r, input int c);
    cur_row = r;
    cur_col = c;
    bus.row = 9'(r);
    bus.col = 10'(c);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_frame[i] = 0;
      m_tick[i]  = 0;
      m_pos[i]   = 0;
    end
    m_prev = 1'b0;
    e_hit  = 0;
    e_id   = 0;
    e_addr = 0;
  endtask

  task automatic advance(input int i);
`ifdef SPRITE_ANIM_PINGPONG_EN
    // Position along the bounce cycle 0..nf-1..1 of length 2*(nf-1).
    if (c_nf[i] <= 1) begin
      m_pos[i]   = 0;
      m_frame[i] = 0;
    end else begin
      m_pos[i]   = (m_pos[i] + 1) % (2 * (c_nf[i] - 1));
      m_frame[i] = (m_pos[i] < c_nf[i]) ? m_pos[i] : 2 * (c_nf[i] - 1) - m_pos[i];
    end
`else
    m_frame[i] = (m_frame[i] + 1 < c_nf[i]) ? m_frame[i] + 1 : 0;
`endif
  endtask

  task automatic step_model();
    bit found;
    bit origin;
    bit vs;
    found = 1'b0;
    e_hit = 0;
    e_id  = 0;
    for (int i = 0; i < NS; i++) begin
      if (!found && c_en[i] != 0 &&
          cur_row >= c_y[i] && cur_row < c_y[i] + SH &&
          cur_col >= c_x[i] && cur_col < c_x[i] + SW) begin
        found  = 1'b1;
        e_hit  = 1;
        e_id   = i;
        e_addr = (c_base[i] + m_frame[i] * SW * SH + (cur_row - c_y[i]) * SW
                  + (cur_col - c_x[i])) % (1 << AW);
      end
    end
    origin = (cur_row == 0) && (cur_col == 0);
    vs     = origin && !m_prev;
    m_prev = origin;
    for (int i = 0; i < NS; i++) begin
      if (c_en[i] == 0) begin
        m_frame[i] = 0;
        m_tick[i]  = 0;
        m_pos[i]   = 0;
      end else if (vs) begin
        if (m_tick[i] == c_div[i]) begin
          m_tick[i] = 0;
          advance(i);
        end else begin
          m_tick[i] = (m_tick[i] + 1) % (1 << DW);
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    step_model();
    #1;
    check("hit", bus.hit, e_hit);
    check("hit_id", bus.hit_id, e_id);
    check("rom_addr", bus.rom_addr, e_addr);
    for (int i = 0; i < NS; i++)
      check($sformatf("frame_idx%0d", i), bus.frame_idx[FW*i +: FW], m_frame[i]);
  endtask

  task automatic vpulse();
    set_pix(0, 0);
    cycle();
    set_pix(300, 600);
    cycle();
  endtask

  task automatic reset_pulse();
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic cfg_ch(input int i, input int en, input int x, input int y,
                        input int base, input int nf, input int dv);
    c_en[i] = en; c_x[i] = x; c_y[i] = y; c_base[i] = base; c_nf[i] = nf; c_div[i] = dv;
  endtask

  initial begin : main
    int sel, ch, r, c;
    int pp_exp[7];
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    for (int i = 0; i < NS; i++) cfg_ch(i, 0, 0, 0, 0, 0, 0);
    apply_cfg();
    set_pix(300, 600);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hit", bus.hit, 0);
    check("rst_hit_id", bus.hit_id, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_frame_idx", bus.frame_idx, 0);
    reset = 1'b0;

    // Single pixel inside ch0.
    cfg_ch(0, 1, 90, 80, 0, 4, 0);
    apply_cfg();
    set_pix(85, 95);
    cycle();
    check("tp_single_hit", bus.hit, 1);
    check("tp_single_id", bus.hit_id, 0);
    check("tp_single_addr", bus.rom_addr, 105);

    // Three video frames, then the window origin.
    repeat (3) vpulse();
    set_pix(80, 90);
    cycle();
    check("tp_step_frame", bus.frame_idx[1:0], 3);
    check("tp_step_addr", bus.rom_addr, 1200);
    vpulse();
`ifdef SPRITE_ANIM_PINGPONG_EN
    check("tp_step_next", bus.frame_idx[1:0], 2);
`else
    check("tp_step_next", bus.frame_idx[1:0], 0);
`endif

    // Overlapping windows: lowest enabled index wins.
    reset_pulse();
    cfg_ch(0, 1, 10, 10, 0, 4, 0);
    cfg_ch(1, 1, 10, 10, 1600, 4, 0);
    apply_cfg();
    set_pix(10, 10);
    cycle();
    check("tp_prio_id", bus.hit_id, 0);
    check("tp_prio_addr", bus.rom_addr, 0);
    c_en[0] = 0;
    apply_cfg();
    cycle();
    check("tp_prio_id1", bus.hit_id, 1);
    check("tp_prio_addr1", bus.rom_addr, 1600);

    // Divider of 3 with a held origin counting once.
    reset_pulse();
    cfg_ch(0, 1, 90, 80, 0, 4, 2);
    cfg_ch(1, 0, 0, 0, 0, 0, 0);
    apply_cfg();
    set_pix(0, 0);
    repeat (5) cycle();
    set_pix(300, 600);
    cycle();
    check("tp_div_first", bus.frame_idx[1:0], 0);
    vpulse();
    check("tp_div_second", bus.frame_idx[1:0], 0);
    vpulse();
    check("tp_div_third", bus.frame_idx[1:0], 1);
    set_pix(85, 95);
    cycle();
    check("tp_div_addr", bus.rom_addr, 505);
    set_pix(85, 110);
    cycle();
    check("tp_edge_hit", bus.hit, 0);
    check("tp_edge_addr_hold", bus.rom_addr, 505);

`ifdef SPRITE_ANIM_PINGPONG_EN
    reset_pulse();
    cfg_ch(0, 1, 90, 80, 0, 3, 0);
    apply_cfg();
    pp_exp = '{1, 2, 1, 0, 1, 2, 1};
    for (int k = 0; k < 7; k++) begin
      vpulse();
      check($sformatf("tp_pp_%0d", k), bus.frame_idx[1:0], pp_exp[k]);
    end
`else
    // nframes shrinks below the running frame.
    reset_pulse();
    cfg_ch(0, 1, 90, 80, 0, 4, 0);
    apply_cfg();
    repeat (3) vpulse();
    c_nf[0] = 2;
    apply_cfg();
    set_pix(80, 90);
    cycle();
    check("tp_oor_before", bus.frame_idx[1:0], 3);
    vpulse();
    check("tp_oor_after", bus.frame_idx[1:0], 0);
    pp_exp = '{0, 0, 0, 0, 0, 0, 0};
`endif

    // Asynchronous reset while hitting on frame 2.
    reset_pulse();
    cfg_ch(0, 1, 90, 80, 0, 4, 0);
    apply_cfg();
    repeat (2) vpulse();
    set_pix(85, 95);
    cycle();
    check("tp_arst_pre_hit", bus.hit, 1);
    check("tp_arst_pre_frame", bus.frame_idx[1:0], 2);
    #2 reset = 1'b1;
    #1;
    check("tp_arst_hit", bus.hit, 0);
    check("tp_arst_addr", bus.rom_addr, 0);
    check("tp_arst_id", bus.hit_id, 0);
    check("tp_arst_frame", bus.frame_idx, 0);
    reset = 1'b0;
    model_reset();
    cycle();

    // Randomized epochs, each starting from reset with a fresh configuration.
    for (int ep = 0; ep < 8; ep++) begin
      reset_pulse();
      for (int i = 0; i < NS; i++) begin
        cfg_ch(i, ($urandom_range(0, 9) < 8) ? 1 : 0, int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 511)), int'($urandom_range(0, 4095)),
               int'($urandom_range(0, MF)), int'($urandom_range(0, 3)));
        if (i > 0 && $urandom_range(0, 1) == 1) begin
          c_x[i] = (c_x[0] + int'($urandom_range(0, 12))) % 1024;
          c_y[i] = (c_y[0] + int'($urandom_range(0, 12))) % 512;
        end
      end
      apply_cfg();
      for (int n = 0; n < 400; n++) begin
        sel = int'($urandom_range(0, 15));
        ch  = int'($urandom_range(0, NS - 1));
        if (sel == 0) begin
          set_pix(0, 0);
        end else if (sel >= 2 && sel < 12) begin
          r = (c_y[ch] + int'($urandom_range(0, SH + 3)) - 2) & 511;
          c = (c_x[ch] + int'($urandom_range(0, SW + 3)) - 2) & 1023;
          set_pix(r, c);
        end else if (sel >= 12) begin
          set_pix(int'($urandom_range(0, 511)), int'($urandom_range(0, 1023)));
        end
        if ($urandom_range(0, 127) == 0) begin
          c_en[ch] = (c_en[ch] != 0) ? 0 : 1;
          apply_cfg();
        end
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
